// File: rtl/deframer_checker.sv
// Receive-side frame checker: replay and freshness checks, MAC tag verification, then hand-off.
// Latency: 3 cycles from frame handshake to out_valid when mac_ack arrives on the first MAC cycle.
// Backpressure: one frame in flight; frame_ready is low until the OUT handshake or an error/timeout.
module deframer_checker #(
    parameter int TIME_WINDOW = 8,
    parameter int MAC_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [537:0] frame_in,
    input  logic         frame_valid,
    output logic         frame_ready,
    input  logic [7:0]   local_timer,
    output logic         mac_req,
    output logic [511:0] mac_data,
    output logic [7:0]   mac_counter,
    input  logic         mac_ack,
    input  logic [7:0]   mac_tag,
    output logic [511:0] data_out,
    output logic [7:0]   msg_counter_out,
    output logic [1:0]   state_bits_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err_replay,
    output logic         err_stale,
    output logic         err_auth,
    output logic         err_timeout,
    output logic [7:0]   last_counter
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MAC   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Freshness window bounds, widened to 9 bits so a zero window cannot wrap to 256.
    localparam logic [8:0] TW_LO = 9'(TIME_WINDOW);
    localparam logic [8:0] TW_HI = 9'd256 - 9'(TIME_WINDOW);
    // The MAC engine gets MAC_TIMEOUT cycles (counter values 0..MAC_TIMEOUT-1); the
    // decision on the last one treats a missing ack as a timeout.
    localparam logic [7:0] MAC_LAST = 8'(MAC_TIMEOUT - 1);

    state_t        state_q, state_d;

    // Registered frame fields
    logic [511:0]  payload_q, payload_d;
    logic [7:0]    msg_counter_q, msg_counter_d;
    logic [7:0]    timer_q, timer_d;
    logic [7:0]    auth_tag_q, auth_tag_d;
    logic [1:0]    state_bits_q, state_bits_d;

    // Replay history
    logic [7:0]    last_counter_q, last_counter_d;
    logic          seen_q, seen_d;

    // MAC wait counter
    logic [7:0]    mac_cnt_q, mac_cnt_d;

    // Accepted-frame output registers
    logic [511:0]  data_out_q, data_out_d;
    logic [7:0]    msg_counter_out_q, msg_counter_out_d;
    logic [1:0]    state_bits_out_q, state_bits_out_d;

    // Registered error pulses
    logic          err_replay_q, err_replay_d;
    logic          err_stale_q, err_stale_d;
    logic          err_auth_q, err_auth_d;
    logic          err_timeout_q, err_timeout_d;

    // Rule evaluation on the registered fields
    logic [7:0]    ctr_delta;
    logic [7:0]    age;
    logic          replay_ok;
    logic          fresh_ok;

    // Replay and freshness rules, both modulo-256 distances.
    always_comb begin
        ctr_delta = msg_counter_q - last_counter_q;
        age       = local_timer - timer_q;
        replay_ok = !seen_q || ((ctr_delta != 8'd0) && !ctr_delta[7]);
        fresh_ok  = ({1'b0, age} <= TW_LO) || ({1'b0, age} >= TW_HI);
    end

    // Next-state and datapath update for the four-state frame FSM.
    always_comb begin
        state_d           = state_q;
        payload_d         = payload_q;
        msg_counter_d     = msg_counter_q;
        timer_d           = timer_q;
        auth_tag_d        = auth_tag_q;
        state_bits_d      = state_bits_q;
        last_counter_d    = last_counter_q;
        seen_d            = seen_q;
        mac_cnt_d         = mac_cnt_q;
        data_out_d        = data_out_q;
        msg_counter_out_d = msg_counter_out_q;
        state_bits_out_d  = state_bits_out_q;
        err_replay_d      = 1'b0;
        err_stale_d       = 1'b0;
        err_auth_d        = 1'b0;
        err_timeout_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    payload_d     = frame_in[537:26];
                    msg_counter_d = frame_in[25:18];
                    timer_d       = frame_in[17:10];
                    auth_tag_d    = frame_in[9:2];
                    state_bits_d  = frame_in[1:0];
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                if (replay_ok && fresh_ok) begin
                    mac_cnt_d = 8'd0;
                    state_d   = S_MAC;
                end else begin
                    err_replay_d = !replay_ok;
                    err_stale_d  = !fresh_ok;
                    state_d      = S_IDLE;
                end
            end
            S_MAC: begin
                // An ack always wins over the timeout decision in the same cycle.
                if (mac_ack) begin
                    if (mac_tag == auth_tag_q) begin
                        last_counter_d    = msg_counter_q;
                        seen_d            = 1'b1;
                        data_out_d        = payload_q;
                        msg_counter_out_d = msg_counter_q;
                        state_bits_out_d  = state_bits_q;
                        state_d           = S_OUT;
                    end else begin
                        err_auth_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (mac_cnt_q == MAC_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    mac_cnt_d = mac_cnt_q + 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, replay history and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            last_counter_q <= 8'd0;
            seen_q         <= 1'b0;
            mac_cnt_q      <= 8'd0;
            err_replay_q   <= 1'b0;
            err_stale_q    <= 1'b0;
            err_auth_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_counter_q <= last_counter_d;
            seen_q         <= seen_d;
            mac_cnt_q      <= mac_cnt_d;
            err_replay_q   <= err_replay_d;
            err_stale_q    <= err_stale_d;
            err_auth_q     <= err_auth_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    // Frame field and accepted-output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload_q         <= '0;
            msg_counter_q     <= 8'd0;
            timer_q           <= 8'd0;
            auth_tag_q        <= 8'd0;
            state_bits_q      <= 2'd0;
            data_out_q        <= '0;
            msg_counter_out_q <= 8'd0;
            state_bits_out_q  <= 2'd0;
        end else begin
            payload_q         <= payload_d;
            msg_counter_q     <= msg_counter_d;
            timer_q           <= timer_d;
            auth_tag_q        <= auth_tag_d;
            state_bits_q      <= state_bits_d;
            data_out_q        <= data_out_d;
            msg_counter_out_q <= msg_counter_out_d;
            state_bits_out_q  <= state_bits_out_d;
        end
    end

    // The frame registers only load in IDLE, so they are stable for the whole MAC phase.
    assign frame_ready     = (state_q == S_IDLE);
    assign mac_req         = (state_q == S_MAC);
    assign out_valid       = (state_q == S_OUT);
    assign mac_data        = payload_q;
    assign mac_counter     = msg_counter_q;
    assign data_out        = data_out_q;
    assign msg_counter_out = msg_counter_out_q;
    assign state_bits_out  = state_bits_out_q;
    assign last_counter    = last_counter_q;
    assign err_replay      = err_replay_q;
    assign err_stale       = err_stale_q;
    assign err_auth        = err_auth_q;
    assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_deframer_checker.sv
// Testbench for deframer_checker: directed scenarios then randomized frames.
// A driver pushes the model's expected outcome per frame; a monitor pops on every output event.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_deframer_checker;

    localparam int TW  = 8;
    localparam int MTO = 16;

    logic         clk;
    logic         reset;
    logic [537:0] frame_in;
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   local_timer;
    logic         mac_req;
    logic [511:0] mac_data;
    logic [7:0]   mac_counter;
    logic         mac_ack;
    logic [7:0]   mac_tag;
    logic [511:0] data_out;
    logic [7:0]   msg_counter_out;
    logic [1:0]   state_bits_out;
    logic         out_valid;
    logic         out_ready;
    logic         err_replay, err_stale, err_auth, err_timeout;
    logic [7:0]   last_counter;

    deframer_checker #(.TIME_WINDOW(TW), .MAC_TIMEOUT(MTO)) dut (
        .clk(clk), .reset(reset),
        .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .local_timer(local_timer),
        .mac_req(mac_req), .mac_data(mac_data), .mac_counter(mac_counter),
        .mac_ack(mac_ack), .mac_tag(mac_tag),
        .data_out(data_out), .msg_counter_out(msg_counter_out), .state_bits_out(state_bits_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_replay(err_replay), .err_stale(err_stale), .err_auth(err_auth), .err_timeout(err_timeout),
        .last_counter(last_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind bits: [4] accepted output, [3] replay, [2] stale, [1] auth, [0] timeout
    typedef struct {
        logic [4:0]   kind;
        logic [511:0] data;
        logic [7:0]   ctr;
        logic [1:0]   sb;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: the replay history as the specification defines it.
    int   m_last = 0;
    bit   m_seen = 1'b0;

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endfunction

    // Monitor: every error pulse or output handshake must match the oldest expected event.
    logic [4:0] mon_ev;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            mon_ev = {out_valid && out_ready, err_replay, err_stale, err_auth, err_timeout};
            if (mon_ev != 5'd0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event got %b want none", mon_ev);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", {507'd0, mon_ev}, {507'd0, mon_e.kind});
                    if (mon_ev[4] && mon_e.kind[4]) begin
                        check("data_out", data_out, mon_e.data);
                        check("msg_counter_out", {504'd0, msg_counter_out}, {504'd0, mon_e.ctr});
                        check("state_bits_out", {510'd0, state_bits_out}, {510'd0, mon_e.sb});
                    end
                end
            end
        end
    end

    // Model: decide the outcome from the rules with plain modular arithmetic.
    function automatic exp_t model(input logic [511:0] pl, input int ctr, input int tmr, input int tag,
                                   input int sb, input int lt, input int ack_dly, input int ack_tag);
        exp_t e;
        int d, t;
        bit rep_ok, fr_ok;
        d = (ctr - m_last + 256) % 256;
        t = (lt - tmr + 256) % 256;
        rep_ok = !m_seen || (d >= 1 && d <= 127);
        fr_ok  = (t <= TW) || (t >= 256 - TW);
        e.data = pl;
        e.ctr  = 8'(ctr);
        e.sb   = 2'(sb);
        if (!rep_ok || !fr_ok)   e.kind = {1'b0, !rep_ok, !fr_ok, 2'b00};
        else if (ack_dly >= MTO) e.kind = 5'b00001;
        else if (ack_tag != tag) e.kind = 5'b00010;
        else begin
            e.kind = 5'b10000;
            m_last = ctr;
            m_seen = 1'b1;
        end
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Send one frame through the full exchange; ack_dly >= MTO means the MAC engine never answers.
    task automatic run_frame(input logic [511:0] pl, input int ctr, input int tmr, input int tag,
                             input int sb, input int lt, input int ack_dly, input int ack_tag,
                             input int hold);
        exp_t e;
        int   waited;
        waited = 0;
        while (!frame_ready && waited < 50) begin
            step();
            waited++;
        end
        check("frame_ready_idle", {511'd0, frame_ready}, 512'd1);
        e = model(pl, ctr, tmr, tag, sb, lt, ack_dly, ack_tag);
        exp_q.push_back(e);
        local_timer = 8'(lt);
        frame_in    = {pl, 8'(ctr), 8'(tmr), 8'(tag), 2'(sb)};
        frame_valid = 1'b1;
        step();                      // handshake edge, now in CHECK
        frame_valid = 1'b0;
        check("frame_ready_busy", {511'd0, frame_ready}, 512'd0);
        step();                      // CHECK decision edge
        if (e.kind[3] || e.kind[2]) begin
            check("mac_req_after_reject", {511'd0, mac_req}, 512'd0);
        end else begin
            for (int k = 0; k < MTO; k++) begin
                check("mac_req", {511'd0, mac_req}, 512'd1);
                check("mac_data", mac_data, pl);
                check("mac_counter", {504'd0, mac_counter}, {504'd0, 8'(ctr)});
                if (k == ack_dly) begin
                    mac_ack = 1'b1;
                    mac_tag = 8'(ack_tag);
                    step();
                    mac_ack = 1'b0;
                    break;
                end
                step();
            end
            check("out_valid_timing", {511'd0, out_valid}, {511'd0, e.kind[4]});
            if (e.kind[4]) begin
                for (int h = 0; h < hold; h++) begin
                    check("hold_out_valid", {511'd0, out_valid}, 512'd1);
                    check("hold_frame_ready", {511'd0, frame_ready}, 512'd0);
                    check("hold_data_out", data_out, pl);
                    check("hold_msg_counter_out", {504'd0, msg_counter_out}, {504'd0, 8'(ctr)});
                    step();
                end
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        end
        check("last_counter", {504'd0, last_counter}, 512'(m_last));
    endtask

    function automatic logic [511:0] rand_payload();
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    logic [511:0] pl;
    int ctr, tmr, tag, lt, dly, atag;

    initial begin
        reset       = 1'b1;
        frame_in    = '0;
        frame_valid = 1'b0;
        local_timer = 8'd0;
        mac_ack     = 1'b0;
        mac_tag     = 8'd0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mac_req", {511'd0, mac_req}, 512'd0);
        check("rst_out_valid", {511'd0, out_valid}, 512'd0);
        check("rst_errs", {508'd0, err_replay, err_stale, err_auth, err_timeout}, 512'd0);
        check("rst_last_counter", {504'd0, last_counter}, 512'd0);
        check("rst_data_out", data_out, 512'd0);
        check("rst_msg_counter_out", {504'd0, msg_counter_out}, 512'd0);
        check("rst_state_bits_out", {510'd0, state_bits_out}, 512'd0);
        check("rst_mac_data", mac_data, 512'd0);
        check("rst_mac_counter", {504'd0, mac_counter}, 512'd0);
        reset = 1'b0;
        step();
        check("rst_frame_ready", {511'd0, frame_ready}, 512'd1);

        // First frame, ack on the first MAC cycle
        run_frame(rand_payload(), 8'h05, 8'h33, 8'hF0, 1, 8'h35, 0, 8'hF0, 0);
        // Replays: same counter, then distance 128
        run_frame(rand_payload(), 8'h05, 8'h33, 8'hF0, 2, 8'h33, 0, 8'hF0, 0);
        run_frame(rand_payload(), 8'h85, 8'h33, 8'hF0, 2, 8'h33, 0, 8'hF0, 0);
        // Walk the counter up to 0xFE, then wrap to 0x02
        run_frame(rand_payload(), 8'h80, 8'h10, 8'hF0, 0, 8'h10, 1, 8'hF0, 0);
        run_frame(rand_payload(), 8'hFE, 8'h10, 8'hF0, 3, 8'h18, 0, 8'hF0, 0);
        run_frame(rand_payload(), 8'h02, 8'h10, 8'hF0, 1, 8'h08, 2, 8'hF0, 1);
        // Freshness boundaries across the timer wrap
        run_frame(rand_payload(), 8'h03, 8'hFC, 8'hF0, 0, 8'h04, 0, 8'hF0, 0);
        run_frame(rand_payload(), 8'h04, 8'hFC, 8'hF0, 0, 8'h05, 0, 8'hF0, 0);
        // Replay and stale together
        run_frame(rand_payload(), 8'h03, 8'hFC, 8'hF0, 0, 8'h05, 0, 8'hF0, 0);
        // Auth mismatch, timeout, ack on the last allowed cycle
        run_frame(rand_payload(), 8'h04, 8'h20, 8'hF0, 0, 8'h20, 0, 8'hF1, 0);
        run_frame(rand_payload(), 8'h04, 8'h20, 8'hF0, 0, 8'h20, MTO, 8'hF0, 0);
        run_frame(rand_payload(), 8'h04, 8'h20, 8'hF0, 2, 8'h20, MTO - 1, 8'hF0, 0);
        // Downstream stall for 5 cycles
        run_frame(rand_payload(), 8'h05, 8'h20, 8'hAB, 3, 8'h20, 0, 8'hAB, 5);

        // Reset in the middle of the MAC phase
        pl          = rand_payload();
        local_timer = 8'h40;
        frame_in    = {pl, 8'h06, 8'h40, 8'h11, 2'd1};
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        step();
        step();
        check("mid_mac_req", {511'd0, mac_req}, 512'd1);
        reset = 1'b1;
        #1;
        check("async_rst_mac_req", {511'd0, mac_req}, 512'd0);
        step();
        reset = 1'b0;
        m_last = 0;
        m_seen = 1'b0;
        step();
        check("post_rst_frame_ready", {511'd0, frame_ready}, 512'd1);
        check("post_rst_last_counter", {504'd0, last_counter}, 512'd0);
        check("post_rst_errs", {508'd0, err_replay, err_stale, err_auth, err_timeout}, 512'd0);
        // With no history, a counter equal to last_counter is still accepted
        run_frame(rand_payload(), 8'h00, 8'h50, 8'h22, 0, 8'h50, 0, 8'h22, 0);

        // Randomized frames
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0) ctr = (m_last + $urandom_range(1, 127)) % 256;
            else                           ctr = $urandom_range(0, 255);
            tmr  = $urandom_range(0, 255);
            lt   = (tmr + 244 + $urandom_range(0, 24)) % 256;
            tag  = $urandom_range(0, 255);
            dly  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MTO + 1) : $urandom_range(0, 2);
            atag = ($urandom_range(0, 4) == 0) ? (tag ^ $urandom_range(1, 255)) : tag;
            run_frame(rand_payload(), ctr, tmr, tag, $urandom_range(0, 3), lt, dly, atag,
                      $urandom_range(0, 3));
        end

        step();
        step();
        check("scoreboard_drained", 512'(exp_q.size()), 512'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
